// File: rtl/mem_pkg.sv
// Shared encodings and defaults for the core-to-mainmem arbiter.
package mem_pkg;

   localparam logic READ  = 1'b0;
   localparam logic WRITE = 1'b1;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   localparam logic [31:0] DEFAULT_STARTING_ADDR   = 32'h0100_0000;
   localparam logic [31:0] DEFAULT_MEM_DEPTH_BYTES = 32'h0010_0000;

   typedef enum logic {
      IDLE   = 1'b0,
      RMW_WR = 1'b1
   } arb_state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane handling between 32-bit mainmem words and sized core accesses:
// load extract/extend and sub-word store merge.
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic        zero_ext,
   output logic [31:0] load_data,
   output logic [31:0] merged_word
);

   logic [31:0] byte_sh;
   logic [31:0] half_sh;
   logic [31:0] lane_mask;
   logic [31:0] lane_data;

   always_comb begin
      byte_sh   = old_word >> {addr_lo, 3'b000};
      half_sh   = old_word >> {addr_lo[1], 4'b0000};
      load_data = old_word;
      lane_mask = 32'hFFFF_FFFF;
      lane_data = wdata;
      case (size)
         SIZE_B: begin
            load_data = zero_ext ? {24'h0, byte_sh[7:0]} : {{24{byte_sh[7]}}, byte_sh[7:0]};
            lane_mask = 32'h0000_00FF << {addr_lo, 3'b000};
            lane_data = {24'h0, wdata[7:0]} << {addr_lo, 3'b000};
         end
         SIZE_H: begin
            load_data = zero_ext ? {16'h0, half_sh[15:0]} : {{16{half_sh[15]}}, half_sh[15:0]};
            lane_mask = 32'h0000_FFFF << {addr_lo[1], 4'b0000};
            lane_data = {16'h0, wdata[15:0]} << {addr_lo[1], 4'b0000};
         end
         default: begin
            load_data = old_word;
            lane_mask = 32'hFFFF_FFFF;
            lane_data = wdata;
         end
      endcase
      merged_word = (old_word & ~lane_mask) | (lane_data & lane_mask);
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin sharing of single-port mainmem between instruction fetch and data
// access, with sized loads and read-modify-write for sub-word stores.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter logic [31:0] STARTING_ADDR   = DEFAULT_STARTING_ADDR,
   parameter logic [31:0] MEM_DEPTH_BYTES = DEFAULT_MEM_DEPTH_BYTES
)(
   input  logic        clock,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   output logic        if_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [1:0]  d_size,
   input  logic        d_unsigned,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data_in,
   input  logic [31:0] mem_data_out,
   output logic        mem_read_write
);

   localparam logic [31:0] LAST_WORD_ADDR = STARTING_ADDR + MEM_DEPTH_BYTES - 32'd4;

   arb_state_e  state;
   arb_state_e  state_next;
   owner_e      last_winner;
   logic [31:0] rmw_addr;
   logic [31:0] merge_q;

   logic [31:0] if_word_addr;
   logic [31:0] d_word_addr;
   logic        if_bad;
   logic        d_misaligned;
   logic        d_bad;
   logic        d_sub_store;
   logic [31:0] load_data;
   logic [31:0] merged_word;

   function automatic logic addr_ok(input logic [31:0] word_addr);
      return (word_addr >= STARTING_ADDR) && (word_addr <= LAST_WORD_ADDR);
   endfunction

   mem_lane_align u_lane_align (
      .old_word    (mem_data_out),
      .wdata       (d_wdata),
      .size        (d_size),
      .addr_lo     (d_addr[1:0]),
      .zero_ext    (d_unsigned),
      .load_data   (load_data),
      .merged_word (merged_word)
   );

   // Range is judged on the aligned word so a sub-word access in the last word is legal.
   always_comb begin
      if_word_addr = {if_addr[31:2], 2'b00};
      d_word_addr  = {d_addr[31:2], 2'b00};
      if_bad       = (if_addr[1:0] != 2'b00) || !addr_ok(if_word_addr);
      case (d_size)
         SIZE_B:  d_misaligned = 1'b0;
         SIZE_H:  d_misaligned = d_addr[0];
         SIZE_W:  d_misaligned = (d_addr[1:0] != 2'b00);
         default: d_misaligned = 1'b1;
      endcase
      d_bad       = d_misaligned || !addr_ok(d_word_addr);
      d_sub_store = d_we && !d_bad && (d_size != SIZE_W);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Grants only come out of IDLE; the mainmem port is driven straight from the winner's request.
   always_comb begin
      state_next     = state;
      if_gnt         = 1'b0;
      d_gnt          = 1'b0;
      mem_address    = STARTING_ADDR;
      mem_data_in    = 32'h0;
      mem_read_write = READ;
      case (state)
         IDLE: begin
            if (!reset) begin
               if_gnt = if_req && (!d_req || last_winner == OWN_D);
               d_gnt  = d_req && (!if_req || last_winner == OWN_IF);
            end
            if (d_gnt) begin
               mem_address = d_word_addr;
               if (d_we && !d_bad && d_size == SIZE_W) begin
                  mem_read_write = WRITE;
                  mem_data_in    = d_wdata;
               end else if (d_sub_store) begin
                  state_next = RMW_WR;
               end
            end else if (if_gnt) begin
               mem_address = if_word_addr;
            end
         end
         RMW_WR: begin
            mem_address    = rmw_addr;
            mem_data_in    = merge_q;
            mem_read_write = WRITE;
            state_next     = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Responses are registered one cycle after the grant, or after the RMW write.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last_winner <= OWN_IF;
         rmw_addr    <= STARTING_ADDR;
         merge_q     <= 32'h0;
         if_rvalid   <= 1'b0;
         if_rdata    <= 32'h0;
         if_err      <= 1'b0;
         d_rvalid    <= 1'b0;
         d_rdata     <= 32'h0;
         d_err       <= 1'b0;
      end else begin
         if_rvalid <= if_gnt;
         d_rvalid  <= 1'b0;
         if (if_gnt) begin
            last_winner <= OWN_IF;
            if_err      <= if_bad;
            if_rdata    <= if_bad ? 32'h0 : mem_data_out;
         end
         if (d_gnt) begin
            last_winner <= OWN_D;
            if (d_sub_store) begin
               merge_q  <= merged_word;
               rmw_addr <= d_word_addr;
            end else begin
               d_rvalid <= 1'b1;
               d_err    <= d_bad;
               d_rdata  <= (d_we || d_bad) ? 32'h0 : load_data;
            end
         end
         if (state == RMW_WR) begin
            d_rvalid <= 1'b1;
            d_err    <= 1'b0;
            d_rdata  <= 32'h0;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small mainmem model
// covering the low 256 bytes of the address window.
module tb_mem_arbiter;
   import mem_pkg::*;

   localparam logic [31:0] BASE = 32'h0100_0000;

   logic        clock;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        if_err;
   logic        d_req;
   logic        d_we;
   logic [1:0]  d_size;
   logic        d_unsigned;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        d_err;
   logic [31:0] mem_address;
   logic [31:0] mem_data_in;
   logic [31:0] mem_data_out;
   logic        mem_read_write;

   logic [31:0] mem [64] = '{0: 32'h8899_AABB, 2: 32'hCAFE_F00D, default: 32'h0};
   logic        in_window;
   int          write_cycles = 0;
   int          checks = 0;
   int          failures = 0;

   mem_arbiter dut (
      .clock          (clock),
      .reset          (reset),
      .if_req         (if_req),
      .if_addr        (if_addr),
      .if_gnt         (if_gnt),
      .if_rvalid      (if_rvalid),
      .if_rdata       (if_rdata),
      .if_err         (if_err),
      .d_req          (d_req),
      .d_we           (d_we),
      .d_size         (d_size),
      .d_unsigned     (d_unsigned),
      .d_addr         (d_addr),
      .d_wdata        (d_wdata),
      .d_gnt          (d_gnt),
      .d_rvalid       (d_rvalid),
      .d_rdata        (d_rdata),
      .d_err          (d_err),
      .mem_address    (mem_address),
      .mem_data_in    (mem_data_in),
      .mem_data_out   (mem_data_out),
      .mem_read_write (mem_read_write)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   assign in_window    = (mem_address >= BASE) && (mem_address < BASE + 32'd256);
   assign mem_data_out = in_window ? mem[mem_address[7:2]] : 32'h0;

   always @(posedge clock) begin
      if (mem_read_write && in_window) mem[mem_address[7:2]] <= mem_data_in;
      if (mem_read_write) write_cycles <= write_cycles + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err,
                                output int lat, output int writes);
      int start_w;
      int wait_n;
      @(negedge clock);
      d_req = 1'b1; d_we = we; d_size = size; d_unsigned = uns; d_addr = addr; d_wdata = wdata;
      #1;
      wait_n = 0;
      while (!d_gnt && wait_n < 10) begin
         @(negedge clock); #1; wait_n++;
      end
      if (!d_gnt) checkOutput("d_gnt_timeout", 32'd0, 32'd1);
      start_w = write_cycles;
      @(posedge clock); #1;
      d_req = 1'b0;
      lat = 1;
      while (!d_rvalid && lat < 6) begin
         @(posedge clock); #1; lat++;
      end
      rdata  = d_rdata;
      err    = d_err;
      writes = write_cycles - start_w;
   endtask

   task automatic applyFetch(input logic [31:0] addr, output logic [31:0] rdata,
                             output logic err, output int lat);
      int wait_n;
      @(negedge clock);
      if_req = 1'b1; if_addr = addr;
      #1;
      wait_n = 0;
      while (!if_gnt && wait_n < 10) begin
         @(negedge clock); #1; wait_n++;
      end
      if (!if_gnt) checkOutput("if_gnt_timeout", 32'd0, 32'd1);
      @(posedge clock); #1;
      if_req = 1'b0;
      lat = 1;
      while (!if_rvalid && lat < 6) begin
         @(posedge clock); #1; lat++;
      end
      rdata = if_rdata;
      err   = if_err;
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          wr;
      int          w0;
      int          grants;
      int          dual;
      logic [3:0]  seq;

      reset = 1'b1; if_req = 1'b0; if_addr = BASE; d_req = 1'b0; d_we = 1'b0;
      d_size = SIZE_W; d_unsigned = 1'b0; d_addr = BASE; d_wdata = 32'h0;
      #12;
      checkOutput("rst_if_gnt", {31'h0, if_gnt}, 32'd0);
      checkOutput("rst_d_gnt", {31'h0, d_gnt}, 32'd0);
      checkOutput("rst_d_rvalid", {31'h0, d_rvalid}, 32'd0);
      checkOutput("rst_if_rvalid", {31'h0, if_rvalid}, 32'd0);
      checkOutput("rst_d_rdata", d_rdata, 32'd0);
      checkOutput("rst_rw", {31'h0, mem_read_write}, 32'd0);
      checkOutput("rst_mem_address", mem_address, BASE);
      checkOutput("rst_mem_data_in", mem_data_in, 32'd0);
      @(negedge clock);
      reset = 1'b0;

      // Both requesters held high: D must win the first conflict, then alternate.
      @(negedge clock);
      if_req = 1'b1; if_addr = BASE; d_req = 1'b1; d_we = 1'b0; d_size = SIZE_W; d_addr = BASE + 32'd4;
      #1;
      grants = 0; dual = 0; seq = 4'b0;
      for (int c = 0; c < 20 && grants < 4; c++) begin
         if (if_gnt && d_gnt) dual++;
         if (if_gnt || d_gnt) begin
            seq = {seq[2:0], d_gnt};
            grants++;
         end
         @(negedge clock); #1;
      end
      if_req = 1'b0; d_req = 1'b0;
      checkOutput("arb_grants", grants, 32'd4);
      checkOutput("arb_order_DIDI", {28'h0, seq}, 32'h0000_000A);
      checkOutput("arb_dual_gnt", dual, 32'd0);

      applyStimulus(1'b0, SIZE_B, 1'b0, BASE + 32'd3, 32'h0, rd, er, lat, wr);
      checkOutput("lb_rdata", rd, 32'hFFFF_FF88);
      checkOutput("lb_latency", lat, 32'd1);
      checkOutput("lb_err", {31'h0, er}, 32'd0);
      applyStimulus(1'b0, SIZE_B, 1'b1, BASE + 32'd3, 32'h0, rd, er, lat, wr);
      checkOutput("lbu_rdata", rd, 32'h0000_0088);
      applyStimulus(1'b0, SIZE_H, 1'b0, BASE + 32'd2, 32'h0, rd, er, lat, wr);
      checkOutput("lh_rdata", rd, 32'hFFFF_8899);
      applyStimulus(1'b0, SIZE_H, 1'b1, BASE, 32'h0, rd, er, lat, wr);
      checkOutput("lhu_rdata", rd, 32'h0000_AABB);

      applyStimulus(1'b1, SIZE_B, 1'b0, BASE + 32'd1, 32'h0000_005A, rd, er, lat, wr);
      checkOutput("sb_writes", wr, 32'd1);
      checkOutput("sb_latency", lat, 32'd2);
      checkOutput("sb_err", {31'h0, er}, 32'd0);
      checkOutput("sb_rdata", rd, 32'd0);
      applyStimulus(1'b0, SIZE_W, 1'b0, BASE, 32'h0, rd, er, lat, wr);
      checkOutput("sb_readback", rd, 32'h8899_5ABB);

      applyStimulus(1'b1, SIZE_W, 1'b0, BASE + 32'd4, 32'h1234_5678, rd, er, lat, wr);
      checkOutput("sw_writes", wr, 32'd1);
      checkOutput("sw_latency", lat, 32'd1);
      applyStimulus(1'b0, SIZE_W, 1'b0, BASE + 32'd4, 32'h0, rd, er, lat, wr);
      checkOutput("sw_readback", rd, 32'h1234_5678);

      applyStimulus(1'b0, SIZE_W, 1'b0, BASE + 32'd2, 32'h0, rd, er, lat, wr);
      checkOutput("lw_mis_err", {31'h0, er}, 32'd1);
      checkOutput("lw_mis_rdata", rd, 32'd0);
      checkOutput("lw_mis_writes", wr, 32'd0);
      applyStimulus(1'b1, SIZE_H, 1'b0, BASE + 32'd1, 32'hFFFF, rd, er, lat, wr);
      checkOutput("sh_mis_err", {31'h0, er}, 32'd1);
      checkOutput("sh_mis_writes", wr, 32'd0);
      checkOutput("sh_mis_latency", lat, 32'd1);
      applyStimulus(1'b0, 2'd3, 1'b0, BASE, 32'h0, rd, er, lat, wr);
      checkOutput("size3_err", {31'h0, er}, 32'd1);
      applyStimulus(1'b0, SIZE_W, 1'b0, 32'h010F_FFFC, 32'h0, rd, er, lat, wr);
      checkOutput("last_word_err", {31'h0, er}, 32'd0);
      applyStimulus(1'b0, SIZE_W, 1'b0, 32'h0110_0000, 32'h0, rd, er, lat, wr);
      checkOutput("past_end_err", {31'h0, er}, 32'd1);
      applyStimulus(1'b0, SIZE_B, 1'b0, 32'h00FF_FFFF, 32'h0, rd, er, lat, wr);
      checkOutput("below_base_err", {31'h0, er}, 32'd1);

      applyFetch(BASE, rd, er, lat);
      checkOutput("fetch_rdata", rd, 32'h8899_5ABB);
      checkOutput("fetch_latency", lat, 32'd1);
      checkOutput("fetch_err", {31'h0, er}, 32'd0);
      applyFetch(32'h0110_0000, rd, er, lat);
      checkOutput("fetch_oor_err", {31'h0, er}, 32'd1);
      checkOutput("fetch_oor_rdata", rd, 32'd0);
      applyFetch(BASE + 32'd2, rd, er, lat);
      checkOutput("fetch_mis_err", {31'h0, er}, 32'd1);

      // Reset lands while the RMW write is pending: the write must be dropped.
      @(negedge clock);
      d_req = 1'b1; d_we = 1'b1; d_size = SIZE_H; d_unsigned = 1'b0; d_addr = BASE + 32'd8; d_wdata = 32'h0000_BEEF;
      #1;
      checkOutput("rmw_gnt", {31'h0, d_gnt}, 32'd1);
      w0 = write_cycles;
      @(posedge clock); #1;
      d_req = 1'b0;
      checkOutput("rmw_pending_write", {31'h0, mem_read_write}, 32'd1);
      #2 reset = 1'b1;
      #1;
      checkOutput("rmw_rst_rw", {31'h0, mem_read_write}, 32'd0);
      checkOutput("rmw_rst_address", mem_address, BASE);
      @(posedge clock); #1;
      checkOutput("rmw_rst_rvalid", {31'h0, d_rvalid}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      checkOutput("rmw_rst_writes", write_cycles - w0, 32'd0);
      applyStimulus(1'b0, SIZE_W, 1'b0, BASE + 32'd8, 32'h0, rd, er, lat, wr);
      checkOutput("rmw_rst_word", rd, 32'hCAFE_F00D);

      $display("%0d/%0d checks passed", checks - failures, checks);
      $finish;
   end

endmodule
